// File: rtl/forward_neuron_module.sv
// Single four-input neuron forward pass: z = sum(x_i * w_i) + bias in Q6.10,
// followed by a ReLU activation and its derivative for the backprop stage.
// Sequenced as IDLE -> MAC (4 cycles, one product per cycle) -> ACT.
module forward_neuron_module (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] x3,
    input  logic [15:0] x4,
    input  logic [15:0] w1,
    input  logic [15:0] w2,
    input  logic [15:0] w3,
    input  logic [15:0] w4,
    input  logic [15:0] bias,
    output logic        busy,
    output logic        done,
    output logic [15:0] a,
    output logic [15:0] dadz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2
    } state_t;

    state_t             state;
    logic        [1:0]  idx;
    logic signed [35:0] acc;
    logic signed [15:0] x_q [4];
    logic signed [15:0] w_q [4];

    logic signed [15:0] mac_x;
    logic signed [15:0] mac_w;
    logic signed [31:0] product;
    logic signed [35:0] acc_shr;
    logic signed [15:0] z_sat;
    logic               z_pos;

    // Select the operand pair for the current MAC step and form the full-width product
    always_comb begin
        mac_x   = x_q[idx];
        mac_w   = w_q[idx];
        product = 32'(mac_x) * 32'(mac_w);
    end

    // Rescale the Q12.20 accumulator back to Q6.10 (floor) and saturate to 16 bits
    always_comb begin
        acc_shr = acc >>> 10;
        if (acc_shr > 36'sd32767) begin
            z_sat = 16'sh7FFF;
        end else if (acc_shr < -36'sd32768) begin
            z_sat = 16'sh8000;
        end else begin
            z_sat = acc_shr[15:0];
        end
        z_pos = (z_sat > 16'sd0);
    end

    // Evaluation sequencer: capture, accumulate, activate; all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
            done  <= 1'b0;
            a     <= '0;
            dadz  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q[0] <= x1;
                        x_q[1] <= x2;
                        x_q[2] <= x3;
                        x_q[3] <= x4;
                        w_q[0] <= w1;
                        w_q[1] <= w2;
                        w_q[2] <= w3;
                        w_q[3] <= w4;
                        // Bias is pre-scaled to the product's Q12.20 format; the
                        // accumulator itself serves as the captured bias register.
                        acc    <= {{10{bias[15]}}, bias, 10'b0};
                        idx    <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + 36'(product);
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state <= ACT;
                    end
                end
                ACT: begin
                    a     <= z_pos ? z_sat : 16'h0000;
                    dadz  <= z_pos ? 16'h0400 : 16'h0000;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy is a pure decode of the registered state
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_forward_neuron_module.sv
// Directed bench for forward_neuron_module: hand-computed Q6.10 results,
// latency, busy/start handling, back-to-back issue and asynchronous reset.
module tb_forward_neuron_module;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x1, x2, x3, x4;
    logic [15:0] w1, w2, w3, w4;
    logic [15:0] bias;
    logic        busy;
    logic        done;
    logic [15:0] a;
    logic [15:0] dadz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forward_neuron_module dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .x4    (x4),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .w4    (w4),
        .bias  (bias),
        .busy  (busy),
        .done  (done),
        .a     (a),
        .dadz  (dadz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // xs = {x4,x3,x2,x1}, ws = {w4,w3,w2,w1}
    task automatic set_ops(input logic [63:0] xs, input logic [63:0] ws, input logic [15:0] b);
        x1 = xs[15:0];  x2 = xs[31:16]; x3 = xs[47:32]; x4 = xs[63:48];
        w1 = ws[15:0];  w2 = ws[31:16]; w3 = ws[47:32]; w4 = ws[63:48];
        bias = b;
    endtask

    // Present operands with a one-cycle start pulse; returns 1 ns after the accept edge
    task automatic launch(input string tag, input logic [63:0] xs, input logic [63:0] ws,
                          input logic [15:0] b);
        @(negedge clk);
        set_ops(xs, ws, b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
    endtask

    // Wait (bounded) for done; done must appear 5 edges after the accept edge
    task automatic expect_result(input string tag, input logic [15:0] ea, input logic [15:0] ed);
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_a"}, 32'(a), 32'(ea));
        check({tag, "_dadz"}, 32'(dadz), 32'(ed));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    task automatic expect_pulse_end(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] xs, input logic [63:0] ws,
                           input logic [15:0] b, input logic [15:0] ea, input logic [15:0] ed);
        launch(tag, xs, ws, b);
        expect_result(tag, ea, ed);
        expect_pulse_end(tag);
    endtask

    localparam logic [63:0] X_ONES  = {4{16'h0400}};
    localparam logic [63:0] W_NOM   = {16'h0080, 16'h0100, 16'h0200, 16'h0400};
    localparam logic [63:0] W_NEG   = {4{16'hFC00}};
    localparam logic [63:0] ALL_MAX = {4{16'h7FFF}};

    initial begin
        int pulses;
        int first_at;

        rst   = 1'b0;
        start = 1'b0;
        set_ops('0, '0, '0);
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_a",    32'(a),    32'd0);
        check("rst_dadz", 32'(dadz), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1.0*1.0 + 1.0*0.5 + 1.0*0.25 + 1.0*0.125 = 1.875
        run_vec("nominal", X_ONES, W_NOM, 16'h0000, 16'h0780, 16'h0400);
        // -4.0
        run_vec("negative", X_ONES, W_NEG, 16'h0000, 16'h0000, 16'h0000);
        // Far above 32767 after rescale -> saturate high
        run_vec("sat_pos", ALL_MAX, ALL_MAX, 16'h7FFF, 16'h7FFF, 16'h0400);
        // Far below -32768 -> saturate low, ReLU clamps to zero
        run_vec("sat_neg", ALL_MAX, {4{16'h8000}}, 16'h8000, 16'h0000, 16'h0000);
        run_vec("bias_only", '0, W_NOM, 16'h0800, 16'h0800, 16'h0400);
        run_vec("all_zero", '0, W_NOM, 16'h0000, 16'h0000, 16'h0000);
        // 1.5*1.5 = 2.25
        run_vec("frac", {48'h0, 16'h0600}, {48'h0, 16'h0600}, 16'h0000, 16'h0900, 16'h0400);
        // 3*341 = 1023 LSBs of Q12.20 -> floor gives z=0, so ReLU output 0
        run_vec("floor", {48'h0, 16'h0003}, {48'h0, 16'h0155}, 16'h0000, 16'h0000, 16'h0000);
        // 1 LSB * 1.0 -> z = 1 LSB
        run_vec("one_lsb", {48'h0, 16'h0001}, {48'h0, 16'h0400}, 16'h0000, 16'h0001, 16'h0400);
        // 1.0*2.0 + (-1.0) = 1.0, checks bias sign extension
        run_vec("neg_bias", {48'h0, 16'h0400}, {48'h0, 16'h0800}, 16'hFC00, 16'h0400, 16'h0400);

        // start held for three cycles from accept: only one evaluation
        @(negedge clk);
        set_ops(X_ONES, W_NOM, 16'h0000);
        start = 1'b1;
        @(posedge clk);
        #1;
        pulses   = 0;
        first_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
        end
        check("held_start_pulses", 32'(pulses), 32'd1);
        check("held_start_edge", 32'(first_at), 32'd5);
        check("held_start_a", 32'(a), 32'h0780);

        // Operands changed right after the capture edge must not matter
        launch("opchange", X_ONES, W_NOM, 16'h0000);
        set_ops(ALL_MAX, ALL_MAX, 16'h7FFF);
        expect_result("opchange", 16'h0780, 16'h0400);
        expect_pulse_end("opchange");

        // Back-to-back: second start issued in the done cycle
        launch("b2b_first", X_ONES, W_NOM, 16'h0000);
        expect_result("b2b_first", 16'h0780, 16'h0400);
        launch("b2b_second", X_ONES, W_NEG, 16'h0000);
        expect_result("b2b_second", 16'h0000, 16'h0000);
        expect_pulse_end("b2b_second");

        // Reset in the second MAC cycle, with a=0x0780 left from a prior result
        run_vec("pre_reset", X_ONES, W_NOM, 16'h0000, 16'h0780, 16'h0400);
        launch("reset_mid", X_ONES, W_NOM, 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_done", 32'(done), 32'd0);
        check("reset_mid_a",    32'(a),    32'd0);
        check("reset_mid_dadz", 32'(dadz), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("reset_mid_no_done", 32'(pulses), 32'd0);
        check("reset_mid_idle", 32'(busy), 32'd0);
        run_vec("post_reset", X_ONES, W_NOM, 16'h0000, 16'h0780, 16'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
